uart_rx_cfg: RTL and testbench
==============================

# uart_rx_cfg

Configurable UART receiver, the next-generation replacement for the fixed 8N1 receiver in the CPU's serial front end. Adds a compile-time frame format (data bits, parity, stop bits), a runtime baud divisor, input synchronisation, 3-sample majority voting, false-start rejection and per-frame parity/framing error flags. It sits between the board RX pin and the command decoder and delivers one strobed word per frame.

## Interface
- DATA_BITS, 8, data bits per frame, legal range 5..9
- PARITY_EN, 0, 1 = parity bit present after data
- PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd
- STOP_BITS, 1, stop bits per frame, 1 or 2
- DIV_WIDTH, 16, width of baud divisor
- clk_i  in  1  system clock
- reset_i  in  1  asynchronous, active-high reset
- rx_i  in  1  serial line, idle high, asynchronous to clk_i
- baud_div_i  in  DIV_WIDTH  clock cycles per bit D, legal D >= 4
- data_o  out  DATA_BITS  last received word, LSB = first data bit
- data_valid_strb_o  out  1  one-cycle strobe, new frame on data_o
- parity_err_o  out  1  parity mismatch of last frame (0 if PARITY_EN=0)
- frame_err_o  out  1  a stop bit of last frame sampled low

## Operation
- rx_i passes through a 2-flop synchroniser (both flops reset to 1); all logic uses the synchronised value rs.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: rs==0 -> START; latch baud_div_i as D and H = D>>1; bit timer t = 0 in the cycle rs is first seen low. D is constant for the whole frame.
- Bit timer counts 0..D-1 then wraps to 0 and advances the bit index.
- Sampling: in every bit, rs is sampled at t = H-1, H, H+1; bit value = majority of the 3; decision taken at t = H+1.
- START decision 1 -> false start: return to IDLE, no strobe, no output change. Decision 0 -> DATA after the bit period ends.
- DATA: DATA_BITS bits shifted in LSB first; bit counter 0..DATA_BITS-1; then PARITY if PARITY_EN else STOP.
- PARITY: expected = XOR(data) XOR PARITY_ODD; mismatch sets internal parity error.
- STOP: each stop bit decided as above; any stop decision 0 sets internal framing error. At the decision of the last stop bit, go straight to IDLE (do not wait out the bit) so the next start edge is caught.
- On that last-stop decision: data_o, parity_err_o, frame_err_o load together and data_valid_strb_o pulses. Word delivered even with errors.
- Outputs hold until the next strobe; false starts never change them.
- In IDLE while rs is still low after a framing-error frame: re-enter START only on a new 1->0 transition of rs (break does not repeat frames).

## Timing
- Reset: state IDLE, data_o = 0, data_valid_strb_o = 0, parity_err_o = 0, frame_err_o = 0, timers/counters 0.
- Pin-to-rs latency: 2 cycles.
- Frame bits N = 1 + DATA_BITS + PARITY_EN + STOP_BITS. Strobe asserted in the cycle after the last-stop decision, i.e. at t_rel = (N-1)*D + H + 2, relative to the cycle rs first reads low. All outputs are registered and valid in that same cycle.
- data_valid_strb_o is high for exactly 1 cycle.
- Reset mid-frame: immediate return to IDLE, outputs cleared, no strobe. The partial frame is discarded; the receiver resyncs on the next falling edge.
- baud_div_i changes take effect at the next start bit only.
- D < 4 is illegal; behaviour is unspecified.

## Test plan
- 8N1, D=16, send 0xA5 -> one strobe, data_o=0xA5, both error flags 0, strobe 9*16+8+2 cycles after rs first low.
- 8E1 (PARITY_EN=1), D=16: send 0x3C with correct parity -> parity_err_o=0. Send 0x3C with a flipped parity bit -> data_o=0x3C, parity_err_o=1.
- Stop bit driven low, then line returns high -> strobe with frame_err_o=1. Line then held low 30 bit periods -> no further strobes until a new falling edge.
- 3-cycle low glitch on idle line, D=16 -> no strobe, outputs unchanged. 1-cycle glitch inside data bit 2 of 0x00 -> data_o=0x00 (majority vote).
- 7O2 (DATA_BITS=7, PARITY_ODD=1, STOP_BITS=2), D=5: back-to-back frames 0x55, 0x2A with no idle gap -> two strobes with correct data and no errors.
- reset_i pulsed during data bit 4 -> outputs 0 and no strobe; the following 0x81 frame is received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: compile-time frame format, runtime baud divisor,
// 3-sample majority voting, false-start rejection and per-frame error flags.
module uart_rx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 rx_i,
  input  logic [DIV_WIDTH-1:0] baud_div_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 data_valid_strb_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state, state_nx;
  logic                   sync1, rs;
  logic [DIV_WIDTH-1:0]   d_lat, h_lat, t;
  logic [3:0]             bit_cnt;
  logic                   samp_a, samp_b;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_err, frm_err;
  logic                   armed;
  logic                   decide, maj, bit_end, last_data, last_stop, go;

  always_comb begin
    decide    = (t == h_lat + DIV_WIDTH'(1));
    bit_end   = (t == d_lat - DIV_WIDTH'(1));
    maj       = (samp_a & samp_b) | (samp_a & rs) | (samp_b & rs);
    last_data = (bit_cnt == 4'(DATA_BITS - 1));
    last_stop = (bit_cnt == 4'(STOP_BITS - 1));
    // armed drops after a framing-error frame so a held break cannot restart
    go        = !rs && armed;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (go) state_nx = START;
      START:  if (decide && maj) state_nx = IDLE;
              else if (bit_end) state_nx = DATA;
      DATA:   if (bit_end && last_data) state_nx = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY: if (bit_end) state_nx = STOP;
      STOP:   if (decide && last_stop) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nx;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1             <= 1'b1;
      rs                <= 1'b1;
      d_lat             <= '0;
      h_lat             <= '0;
      t                 <= '0;
      bit_cnt           <= '0;
      samp_a            <= 1'b0;
      samp_b            <= 1'b0;
      shreg             <= '0;
      par_err           <= 1'b0;
      frm_err           <= 1'b0;
      armed             <= 1'b1;
      data_o            <= '0;
      data_valid_strb_o <= 1'b0;
      parity_err_o      <= 1'b0;
      frame_err_o       <= 1'b0;
    end else begin
      sync1             <= rx_i;
      rs                <= sync1;
      data_valid_strb_o <= 1'b0;
      if (rs) armed <= 1'b1;
      if (t == h_lat - DIV_WIDTH'(1)) samp_a <= rs;
      if (t == h_lat)                 samp_b <= rs;

      if (state == IDLE) begin
        if (go) begin
          // the first-low cycle is t=0 of the start bit
          d_lat   <= baud_div_i;
          h_lat   <= baud_div_i >> 1;
          t       <= DIV_WIDTH'(1);
          bit_cnt <= '0;
          par_err <= 1'b0;
          frm_err <= 1'b0;
        end
      end else begin
        if (bit_end) begin
          t       <= '0;
          bit_cnt <= (state_nx != state) ? 4'd0 : bit_cnt + 4'd1;
        end else begin
          t <= t + DIV_WIDTH'(1);
        end
        if (state_nx == IDLE) t <= '0;

        if (decide) begin
          case (state)
            DATA:   shreg   <= {maj, shreg[DATA_BITS-1:1]};
            PARITY: par_err <= (^shreg) ^ 1'(PARITY_ODD) ^ maj;
            STOP: begin
              if (!maj) frm_err <= 1'b1;
              if (last_stop) begin
                data_o            <= shreg;
                parity_err_o      <= par_err;
                frame_err_o       <= frm_err | ~maj;
                data_valid_strb_o <= 1'b1;
                if (frm_err | ~maj) armed <= 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three instances (8N1, 8E1, 7O2) share the
// clock and reset; each frame's expected word is queued when it is driven.
module tb_uart_rx_cfg;

  typedef struct {logic [8:0] data; logic pe; logic fe;} sb_t;

  logic        clk = 1'b0, reset_i = 1'b1;
  logic        rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
  logic [15:0] div_a = 16'd16, div_b = 16'd16, div_c = 16'd5;
  logic [7:0]  data_a, data_b;
  logic [6:0]  data_c;
  logic        strb_a, strb_b, strb_c, pe_a, pe_b, pe_c, fe_a, fe_b, fe_c;

  int   n_vec = 0, n_err = 0, cyc = 0, exp_cyc_a = 0;
  sb_t  qa[$], qb[$], qc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg u_a (.clk_i(clk), .reset_i(reset_i), .rx_i(rx_a), .baud_div_i(div_a),
    .data_o(data_a), .data_valid_strb_o(strb_a), .parity_err_o(pe_a), .frame_err_o(fe_a));
  uart_rx_cfg #(.PARITY_EN(1)) u_b (.clk_i(clk), .reset_i(reset_i), .rx_i(rx_b),
    .baud_div_i(div_b), .data_o(data_b), .data_valid_strb_o(strb_b),
    .parity_err_o(pe_b), .frame_err_o(fe_b));
  uart_rx_cfg #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_c (
    .clk_i(clk), .reset_i(reset_i), .rx_i(rx_c), .baud_div_i(div_c), .data_o(data_c),
    .data_valid_strb_o(strb_c), .parity_err_o(pe_c), .frame_err_o(fe_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_line(input int which, input logic v);
    case (which)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  // Drives one frame from a negedge. glitch_at inverts the line for one cycle,
  // reset_at pulses reset for two cycles (frame then discarded, nothing queued).
  task automatic send(input int which, input logic [8:0] data, input int nd, input bit pen,
                      input bit podd, input int nstop, input bit flip_par, input bit stop_low,
                      input int d, input int glitch_at, input int reset_at, input bit chk_lat);
    logic [15:0] fr;
    logic [8:0]  m;
    int          n;
    sb_t         e;
    m = 9'((1 << nd) - 1);
    fr = '0;
    n = 1;
    for (int i = 0; i < nd; i++) begin fr[n] = data[i]; n++; end
    if (pen) begin fr[n] = (^(data & m)) ^ podd ^ flip_par; n++; end
    for (int s = 0; s < nstop; s++) begin fr[n] = !stop_low; n++; end
    e.data = data & m; e.pe = flip_par; e.fe = stop_low;
    if (reset_at < 0)
      case (which)
        0: qa.push_back(e);
        1: qb.push_back(e);
        default: qc.push_back(e);
      endcase
    if (chk_lat) exp_cyc_a = cyc + 2 + (n - 1) * d + d / 2 + 2;
    for (int i = 0; i < n; i++)
      for (int c = 0; c < d; c++) begin
        set_line(which, (i * d + c == glitch_at) ? !fr[i] : fr[i]);
        if (i * d + c == reset_at) reset_i = 1'b1;
        if (i * d + c == reset_at + 2) reset_i = 1'b0;
        @(negedge clk);
      end
  endtask

  task automatic idle(input int which, input int cycles);
    set_line(which, 1'b1);
    repeat (cycles) @(negedge clk);
  endtask

  always @(negedge clk) if (strb_a) begin
    if (qa.size() == 0) chk("a_spurious_strobe", 32'(data_a), 32'hDEAD);
    else begin
      sb_t e;
      e = qa.pop_front();
      chk("a_data", 32'(data_a), 32'(e.data));
      chk("a_parity_err", 32'(pe_a), 32'(e.pe));
      chk("a_frame_err", 32'(fe_a), 32'(e.fe));
      if (exp_cyc_a != 0) begin chk("a_latency", 32'(cyc), 32'(exp_cyc_a)); exp_cyc_a = 0; end
    end
  end

  always @(negedge clk) if (strb_b) begin
    if (qb.size() == 0) chk("b_spurious_strobe", 32'(data_b), 32'hDEAD);
    else begin
      sb_t e;
      e = qb.pop_front();
      chk("b_data", 32'(data_b), 32'(e.data));
      chk("b_parity_err", 32'(pe_b), 32'(e.pe));
      chk("b_frame_err", 32'(fe_b), 32'(e.fe));
    end
  end

  always @(negedge clk) if (strb_c) begin
    if (qc.size() == 0) chk("c_spurious_strobe", 32'(data_c), 32'hDEAD);
    else begin
      sb_t e;
      e = qc.pop_front();
      chk("c_data", 32'(data_c), 32'(e.data));
      chk("c_parity_err", 32'(pe_c), 32'(e.pe));
      chk("c_frame_err", 32'(fe_c), 32'(e.fe));
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(data_a), 32'h0);
    chk("rst_strobe", 32'({strb_a, strb_b, strb_c}), 32'h0);
    chk("rst_flags", 32'({pe_a, fe_a, pe_b, fe_b, pe_c, fe_c}), 32'h0);

    // 8N1 basic frame with strobe latency
    send(0, 9'hA5, 8, 0, 0, 1, 0, 0, 16, -1, -1, 1);
    idle(0, 32);
    chk("a_lat_seen", 32'(exp_cyc_a), 32'h0);

    // 3-cycle glitch on idle line: false start, outputs held
    set_line(0, 1'b0);
    repeat (3) @(negedge clk);
    idle(0, 60);
    chk("a_hold_after_glitch", 32'(data_a), 32'hA5);

    // 1-cycle glitch on the middle sample of data bit 2 of 0x00
    send(0, 9'h00, 8, 0, 0, 1, 0, 0, 16, 3 * 16 + 8, -1, 0);
    idle(0, 32);

    // stop bit low, line returns high
    send(0, 9'h5A, 8, 0, 0, 1, 0, 1, 16, -1, -1, 0);
    idle(0, 48);

    // break: frame of zeros with low stop, line held low 30 bit periods
    send(0, 9'h00, 8, 0, 0, 1, 0, 1, 16, -1, -1, 0);
    set_line(0, 1'b0);
    repeat (30 * 16) @(negedge clk);
    idle(0, 48);
    chk("a_break_flag", 32'(fe_a), 32'h1);

    // 8E1: good parity, then flipped parity
    send(1, 9'h3C, 8, 1, 0, 1, 0, 0, 16, -1, -1, 0);
    idle(1, 32);
    send(1, 9'h3C, 8, 1, 0, 1, 1, 0, 16, -1, -1, 0);
    idle(1, 32);

    // 7O2 back-to-back at D=5
    send(2, 9'h55, 7, 1, 1, 2, 0, 0, 5, -1, -1, 0);
    send(2, 9'h2A, 7, 1, 1, 2, 0, 0, 5, -1, -1, 0);
    idle(2, 20);

    // reset during data bit 4, then a clean 0x81
    send(0, 9'hFF, 8, 0, 0, 1, 0, 0, 16, 5 * 16 + 8, 5 * 16 + 5, 0);
    idle(0, 32);
    chk("mid_rst_data_a", 32'(data_a), 32'h0);
    chk("mid_rst_data_b", 32'(data_b), 32'h0);
    chk("mid_rst_flags", 32'({pe_a, fe_a, pe_b, fe_b}), 32'h0);
    send(0, 9'h81, 8, 0, 0, 1, 0, 0, 16, -1, -1, 0);
    idle(0, 32);
    chk("a_final_data", 32'(data_a), 32'h81);

    chk("qa_drained", 32'(qa.size()), 32'h0);
    chk("qb_drained", 32'(qb.size()), 32'h0);
    chk("qc_drained", 32'(qc.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
